// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: scheduler for the HH:MM BCD digit datapath.
// Seconds prescaler, minute/hour carry, debounced time-set FSM, blink mask.
module clock_time_ctrl #(
   parameter int TICK_DIV     = 10000000,
   parameter int SEC_PER_MIN  = 60,
   parameter int DEBOUNCE_CYC = 200000,
   parameter int BLINK_DIV    = 2500000
) (
   input  logic       clk_inbuilt,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [1:0] h1,
   input  logic [3:0] h2,
   input  logic [2:0] m1,
   input  logic [3:0] m2,
   output logic       inc_h1,
   output logic       inc_h2,
   output logic       inc_m1,
   output logic       inc_m2,
   output logic       clr_h1,
   output logic       clr_h2,
   output logic       clr_m1,
   output logic       clr_m2,
   output logic       set_active,
   output logic [3:0] blink_mask
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [2:0] RUN    = 3'd0;
   localparam logic [2:0] SET_H1 = 3'd1;
   localparam logic [2:0] SET_H2 = 3'd2;
   localparam logic [2:0] SET_M1 = 3'd3;
   localparam logic [2:0] SET_M2 = 3'd4;

   logic [2:0]    state;
   logic [1:0]    sync1, sync2, deb, deb_q;
   logic [DW-1:0] dcnt [2];
   logic          mode_p, inc_p;
   logic [PW-1:0] presc;
   logic [SW-1:0] sec;
   logic          tick, min_evt;
   logic [BW-1:0] bcnt;
   logic          phase;
   logic [3:0]    sel;
   logic nx_inc_h1, nx_inc_h2, nx_inc_m1, nx_inc_m2;
   logic nx_clr_h1, nx_clr_h2, nx_clr_m1, nx_clr_m2;

   // Bit 0 is the mode button, bit 1 the increment button.
   assign mode_p = deb[0] & ~deb_q[0];
   assign inc_p  = deb[1] & ~deb_q[1];
   assign tick   = (presc == PW'(TICK_DIV - 1));

   // Synchronize both buttons and accept a level only after it holds steady.
   always_ff @(posedge clk_inbuilt) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 2; i++) dcnt[i] <= '0;
      end else begin
         sync1 <= {btn_inc, btn_mode};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != deb[i]) begin
               if (dcnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                  deb[i]  <= sync2[i];
                  dcnt[i] <= '0;
               end else begin
                  dcnt[i] <= dcnt[i] + 1'b1;
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   // Seconds prescaler; frozen at zero while the time is being set.
   always_ff @(posedge clk_inbuilt) begin
      if (!reset || state != RUN) begin
         presc   <= '0;
         sec     <= '0;
         min_evt <= 1'b0;
      end else begin
         min_evt <= 1'b0;
         if (tick) begin
            presc <= '0;
            if (sec == SW'(SEC_PER_MIN - 1)) begin
               sec     <= '0;
               min_evt <= 1'b1;
            end else begin
               sec <= sec + 1'b1;
            end
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Mode press walks RUN -> H1 -> H2 -> M1 -> M2 -> RUN.
   always_ff @(posedge clk_inbuilt) begin
      if (!reset) begin
         state <= RUN;
      end else if (mode_p) begin
         case (state)
            RUN:     state <= SET_H1;
            SET_H1:  state <= SET_H2;
            SET_H2:  state <= SET_M1;
            SET_M1:  state <= SET_M2;
            default: state <= RUN;
         endcase
      end
   end

   // Next strobe set: minute carry wins over a same-cycle set increment.
   always_comb begin
      nx_inc_h1 = 1'b0;
      nx_inc_h2 = 1'b0;
      nx_inc_m1 = 1'b0;
      nx_inc_m2 = 1'b0;
      nx_clr_h1 = 1'b0;
      nx_clr_h2 = 1'b0;
      nx_clr_m1 = 1'b0;
      nx_clr_m2 = 1'b0;
      if (min_evt) begin
         if (m2 < 4'd9) begin
            nx_inc_m2 = 1'b1;
         end else begin
            nx_clr_m2 = 1'b1;
            if (m1 < 3'd5) begin
               nx_inc_m1 = 1'b1;
            end else begin
               nx_clr_m1 = 1'b1;
               if (h1 >= 2'd2 && h2 >= 4'd3) begin
                  nx_clr_h1 = 1'b1;
                  nx_clr_h2 = 1'b1;
               end else if (h2 >= 4'd9) begin
                  nx_clr_h2 = 1'b1;
                  nx_inc_h1 = 1'b1;
               end else begin
                  nx_inc_h2 = 1'b1;
               end
            end
         end
      end else if (inc_p && !mode_p) begin
         case (state)
            SET_H1: begin
               if (h1 >= 2'd2) nx_clr_h1 = 1'b1;
               else            nx_inc_h1 = 1'b1;
               if (h1 == 2'd1 && h2 > 4'd3) nx_clr_h2 = 1'b1;
            end
            SET_H2: begin
               if (h2 >= ((h1 >= 2'd2) ? 4'd3 : 4'd9)) nx_clr_h2 = 1'b1;
               else                                   nx_inc_h2 = 1'b1;
            end
            SET_M1: begin
               if (m1 >= 3'd5) nx_clr_m1 = 1'b1;
               else            nx_inc_m1 = 1'b1;
            end
            SET_M2: begin
               if (m2 >= 4'd9) nx_clr_m2 = 1'b1;
               else            nx_inc_m2 = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Register strobes so each is a clean single-cycle pulse.
   always_ff @(posedge clk_inbuilt) begin
      if (!reset) begin
         {inc_h1, inc_h2, inc_m1, inc_m2} <= '0;
         {clr_h1, clr_h2, clr_m1, clr_m2} <= '0;
      end else begin
         {inc_h1, inc_h2, inc_m1, inc_m2} <=
            {nx_inc_h1, nx_inc_h2, nx_inc_m1, nx_inc_m2};
         {clr_h1, clr_h2, clr_m1, clr_m2} <=
            {nx_clr_h1, nx_clr_h2, nx_clr_m1, nx_clr_m2};
      end
   end

   // Blink phase generator; idles at zero in RUN.
   always_ff @(posedge clk_inbuilt) begin
      if (!reset || state == RUN) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt + 1'b1;
      end
   end

   // Select the digit being edited for blanking.
   always_comb begin
      case (state)
         SET_H1:  sel = 4'b1000;
         SET_H2:  sel = 4'b0100;
         SET_M1:  sel = 4'b0010;
         SET_M2:  sel = 4'b0001;
         default: sel = 4'b0000;
      endcase
   end

   assign set_active = (state != RUN);
   assign blink_mask = phase ? sel : 4'b0000;

endmodule
